register: RTL and testbench

- 32-entry x 32-bit general-purpose register file for the processor datapath.
- Two combinational read ports and one synchronous write port.
- Register 0 is hardwired to zero.
- Sits between instruction decode (register specifiers) and the ALU/writeback path.

---
 rtl/register.sv | 34 +++
 tb/tb_register.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/register.sv
// register: 32 x 32-bit register file with two combinational read ports and one write port.
// Register 0 is not stored and always reads zero.
module register #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] read_register_1,
    input  logic [ADDR_WIDTH-1:0] read_register_2,
    input  logic [ADDR_WIDTH-1:0] write_register,
    input  logic [DATA_WIDTH-1:0] write_data,
    output logic [DATA_WIDTH-1:0] read_data_1,
    output logic [DATA_WIDTH-1:0] read_data_2
);
    localparam int NUM_REGS = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs_q [1:NUM_REGS-1];
    logic [DATA_WIDTH-1:0] regs_d [1:NUM_REGS-1];

    // A write to specifier 0 is the caller's way of suppressing the write.
    always_comb begin
        regs_d = regs_q;
        if (write_register != '0) regs_d[write_register] = write_data;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) regs_q <= '{default: '0};
        else        regs_q <= regs_d;
    end

    assign read_data_1 = (read_register_1 == '0) ? '0 : regs_q[read_register_1];
    assign read_data_2 = (read_register_2 == '0) ? '0 : regs_q[read_register_2];
endmodule

// File: tb/tb_register.sv
// tb_register: checks the register file against an array model every cycle,
// plus hand-computed expectations for reset, r0, overwrite timing and async reset.
module tb_register;
    logic        clock = 1'b0;
    logic        reset;
    logic [4:0]  read_register_1, read_register_2, write_register;
    logic [31:0] write_data;
    logic [31:0] read_data_1, read_data_2;
    logic [31:0] model [32];
    bit          checking = 1'b0;
    int          n_checks = 0;
    int          n_fail   = 0;

    register #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
        .clock(clock),
        .reset(reset),
        .read_register_1(read_register_1),
        .read_register_2(read_register_2),
        .write_register(write_register),
        .write_data(write_data),
        .read_data_1(read_data_1),
        .read_data_2(read_data_2)
    );

    always #5 clock = ~clock;

    // Model: an array of 32 words where entry 0 is never written.
    always @(posedge clock or negedge reset) begin
        if (!reset) for (int i = 0; i < 32; i++) model[i] = '0;
        else if (write_register != 5'd0) model[write_register] = write_data;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        if (checking) begin
            check("model_rd1", read_data_1, model[read_register_1]);
            check("model_rd2", read_data_2, model[read_register_2]);
        end
    end

    task automatic drive(input logic [4:0] wr, input logic [31:0] wd,
                         input logic [4:0] r1, input logic [4:0] r2);
        @(posedge clock);
        #2;
        write_register  = wr;
        write_data      = wd;
        read_register_1 = r1;
        read_register_2 = r2;
    endtask

    initial begin
        reset = 1'b1;
        write_register = 5'd5;
        write_data = 32'hDEAD_BEEF;
        read_register_1 = 5'd1;
        read_register_2 = 5'd2;
        #1 reset = 1'b0;
        #1 checking = 1'b1;
        // Writes to r5 are attempted on every edge while reset is held low.
        repeat (3) @(posedge clock);
        #2;
        check("reset_r1", read_data_1, 32'd0);
        check("reset_r2", read_data_2, 32'd0);
        read_register_1 = 5'd31;
        read_register_2 = 5'd5;
        #1;
        check("reset_r31", read_data_1, 32'd0);
        check("reset_r5_same_edge", read_data_2, 32'd0);
        reset = 1'b1;
        write_register = 5'd0;

        drive(5'd1, 32'd1, 5'd1, 5'd0);
        drive(5'd0, 32'd0, 5'd1, 5'd0);
        #1;
        check("basic_r1", read_data_1, 32'd1);
        check("basic_r0", read_data_2, 32'd0);

        drive(5'd0, 32'd2, 5'd0, 5'd1);
        drive(5'd0, 32'd0, 5'd0, 5'd1);
        #1;
        check("zero_r0", read_data_1, 32'd0);
        check("zero_r1_kept", read_data_2, 32'd1);

        drive(5'd2, 32'd6, 5'd2, 5'd4);
        drive(5'd3, 32'd7, 5'd2, 5'd4);
        #1;
        check("multi_r2", read_data_1, 32'd6);
        check("unwritten_r4", read_data_2, 32'd0);
        drive(5'd0, 32'd0, 5'd3, 5'd3);
        #1;
        check("same_r3_p1", read_data_1, 32'd7);
        check("same_r3_p2", read_data_2, 32'd7);

        drive(5'd1, 32'd3, 5'd1, 5'd1);
        #1;
        check("overwrite_before_p1", read_data_1, 32'd1);
        check("overwrite_before_p2", read_data_2, 32'd1);
        drive(5'd0, 32'd0, 5'd1, 5'd1);
        #1;
        check("overwrite_after_p1", read_data_1, 32'd3);
        check("overwrite_after_p2", read_data_2, 32'd3);
        drive(5'd0, 32'd0, 5'd2, 5'd3);
        #1;
        check("unchanged_r2", read_data_1, 32'd6);
        check("unchanged_r3", read_data_2, 32'd7);

        drive(5'd0, 32'd0, 5'd1, 5'd2);
        #1 reset = 1'b0;
        #1;
        check("async_r1", read_data_1, 32'd0);
        check("async_r2", read_data_2, 32'd0);
        read_register_2 = 5'd3;
        #1;
        check("async_r3", read_data_2, 32'd0);
        reset = 1'b1;
        drive(5'd31, 32'hFFFF_FFFF, 5'd31, 5'd1);
        drive(5'd0, 32'd0, 5'd31, 5'd1);
        #1;
        check("resume_r31", read_data_1, 32'hFFFF_FFFF);
        check("resume_r1_cleared", read_data_2, 32'd0);

        // Fill every register with a distinct pattern, then read them all back.
        for (int i = 1; i < 32; i++)
            drive(5'(i), 32'h0101_0101 * 32'(i) ^ 32'hA5A5_0000, 5'(i - 1), 5'(i));
        for (int i = 0; i < 32; i++)
            drive(5'd0, 32'hFFFF_FFFF, 5'(i), 5'(31 - i));
        #1;
        check("fill_r31", read_data_1, 32'h1F1F_1F1F ^ 32'hA5A5_0000);
        check("fill_r0", read_data_2, 32'd0);

        repeat (2) @(posedge clock);
        checking = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
